floppy_stepper: RTL and testbench



---
 rtl/floppy_stepper.sv | 161 ++++++++++++++++
 tb/tb_floppy_stepper.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/floppy_stepper.sv
// STEP/DIR driver for one floppy drive: homes the head to track 0, then sweeps
// it back and forth at the half-period given by the note setpoint.
module floppy_stepper #(
  parameter int unsigned TRACKS    = 80,
  parameter logic [21:0] HOME_HALF = 22'd100000,
  parameter logic [21:0] SILENT    = 22'h3fffff
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [21:0] setpoint,
  output logic        step_n,
  output logic        dir,
  output logic        busy,
  output logic [6:0]  position
);

  localparam int unsigned HCW        = $clog2(TRACKS + 1);
  localparam logic [6:0]  LAST_TRACK = 7'(TRACKS - 1);
  localparam logic [HCW-1:0] HOME_STEPS = HCW'(TRACKS);
  localparam logic [HCW-1:0] HOME_ONE   = HCW'(1);

  typedef enum logic [1:0] {
    ST_HOME = 2'd0,
    ST_IDLE = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  state_e          state_q;
  logic [21:0]     cnt_q;
  logic            step_n_q;
  logic            dir_q;
  logic            busy_q;
  logic [6:0]      pos_q;
  logic [HCW-1:0]  homed_q;

  logic [21:0]     half_s;
  logic            toggle_s;
  logic            note_ok_s;
  logic [6:0]      pos_adv_s;
  logic            dir_adv_s;

  // Half-period select, toggle compare and the play-mode head advance.
  // The >= compare lets a shortened setpoint take effect on the next cycle.
  always_comb begin
    half_s    = (state_q == ST_PLAY) ? setpoint : HOME_HALF;
    toggle_s  = (cnt_q >= (half_s - 22'd1));
    note_ok_s = enable && (setpoint != SILENT) && (setpoint != 22'd0);
    pos_adv_s = pos_q;
    dir_adv_s = dir_q;
    if (dir_q) begin
      if (pos_q < LAST_TRACK) begin
        pos_adv_s = pos_q + 7'd1;
        dir_adv_s = ((pos_q + 7'd1) != LAST_TRACK);
      end else begin
        pos_adv_s = pos_q;
        dir_adv_s = 1'b0;
      end
    end else begin
      if (pos_q > 7'd0) begin
        pos_adv_s = pos_q - 7'd1;
        dir_adv_s = ((pos_q - 7'd1) == 7'd0);
      end else begin
        pos_adv_s = pos_q;
        dir_adv_s = 1'b1;
      end
    end
  end

  // Stepper state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_HOME;
      cnt_q    <= 22'd0;
      step_n_q <= 1'b1;
      dir_q    <= 1'b0;
      busy_q   <= 1'b1;
      pos_q    <= LAST_TRACK;
      homed_q  <= '0;
    end else begin
      case (state_q)
        ST_HOME: begin
          dir_q  <= 1'b0;
          busy_q <= 1'b1;
          if (toggle_s) begin
            cnt_q <= 22'd0;
            if (step_n_q && (homed_q == HOME_STEPS)) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              dir_q   <= 1'b1;
              pos_q   <= 7'd0;
            end else begin
              step_n_q <= ~step_n_q;
              if (!step_n_q) begin
                homed_q <= homed_q + HOME_ONE;
                pos_q   <= (pos_q == 7'd0) ? 7'd0 : (pos_q - 7'd1);
              end else begin
                homed_q <= homed_q;
              end
            end
          end else begin
            cnt_q <= cnt_q + 22'd1;
          end
        end

        ST_IDLE: begin
          step_n_q <= 1'b1;
          cnt_q    <= 22'd0;
          busy_q   <= 1'b0;
          if (note_ok_s) begin
            state_q <= ST_PLAY;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_PLAY: begin
          busy_q <= 1'b0;
          // A stop during a low phase still finishes the step so the drive sees a full pulse.
          if (!note_ok_s) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 22'd0;
            step_n_q <= 1'b1;
            if (!step_n_q) begin
              pos_q <= pos_adv_s;
              dir_q <= dir_adv_s;
            end else begin
              pos_q <= pos_q;
            end
          end else if (toggle_s) begin
            cnt_q    <= 22'd0;
            step_n_q <= ~step_n_q;
            if (!step_n_q) begin
              pos_q <= pos_adv_s;
              dir_q <= dir_adv_s;
            end else begin
              pos_q <= pos_q;
            end
          end else begin
            cnt_q <= cnt_q + 22'd1;
          end
        end

        default: begin
          state_q  <= ST_HOME;
          cnt_q    <= 22'd0;
          step_n_q <= 1'b1;
          dir_q    <= 1'b0;
          busy_q   <= 1'b1;
          homed_q  <= '0;
        end
      endcase
    end
  end

  assign step_n   = step_n_q;
  assign dir      = dir_q;
  assign busy     = busy_q;
  assign position = pos_q;

endmodule

// File: tb/tb_floppy_stepper.sv
// Scoreboard bench for floppy_stepper: every change of {step_n,dir,busy,position}
// is matched against a queued expected event carrying its clock-edge index.
module tb_floppy_stepper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [21:0] setpoint;
  logic        step_n;
  logic        dir;
  logic        busy;
  logic [6:0]  position;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int t;

  typedef struct {
    int         cyc;
    logic       sn;
    logic       d;
    logic       b;
    logic [6:0] p;
    string      nm;
  } ev_t;

  ev_t exp_q[$];
  logic [9:0] prev;

  floppy_stepper #(
    .TRACKS   (4),
    .HOME_HALF(22'd3),
    .SILENT   (22'h3fffff)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .setpoint(setpoint),
    .step_n  (step_n),
    .dir     (dir),
    .busy    (busy),
    .position(position)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic sn, input logic d, input logic b,
                      input logic [6:0] p, input string nm);
    ev_t e;
    e.cyc = c; e.sn = sn; e.d = d; e.b = b; e.p = p; e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Homing with TRACKS=4, HOME_HALF=3 after reset release following edge r.
  task automatic push_homing(input int r, input string nm);
    push(r + 3,  1'b0, 1'b0, 1'b1, 7'd3, nm);
    push(r + 6,  1'b1, 1'b0, 1'b1, 7'd2, nm);
    push(r + 9,  1'b0, 1'b0, 1'b1, 7'd2, nm);
    push(r + 12, 1'b1, 1'b0, 1'b1, 7'd1, nm);
    push(r + 15, 1'b0, 1'b0, 1'b1, 7'd1, nm);
    push(r + 18, 1'b1, 1'b0, 1'b1, 7'd0, nm);
    push(r + 21, 1'b0, 1'b0, 1'b1, 7'd0, nm);
    push(r + 24, 1'b1, 1'b0, 1'b1, 7'd0, nm);
    push(r + 27, 1'b1, 1'b1, 1'b0, 7'd0, {nm, "_done"});
  endtask

  // Monitor: any output change is an event that must match the queue head.
  always @(negedge clk) begin
    logic [9:0] cur;
    ev_t e;
    cur = {step_n, dir, busy, position};
    if (cur !== prev) begin
      prev = cur;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d step_n=%b dir=%b busy=%b pos=%0d, required no change",
                 cyc, step_n, dir, busy, position);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (cur !== {e.sn, e.d, e.b, e.p})) begin
          n_fail++;
          $display("FAIL %s: got cycle %0d step_n=%b dir=%b busy=%b pos=%0d, required cycle %0d step_n=%b dir=%b busy=%b pos=%0d",
                   e.nm, cyc, step_n, dir, busy, position, e.cyc, e.sn, e.d, e.b, e.p);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    setpoint = 22'd0;
    push(1, 1'b1, 1'b0, 1'b1, 7'd3, "reset_state");

    // Homing: 4 low pulses of 3 cycles with 3-cycle high gaps.
    tick(2);
    rst_n = 1'b1;
    push_homing(cyc, "home");
    tick(30);

    // SILENT and zero setpoints keep the block idle.
    enable   = 1'b1;
    setpoint = 22'h3fffff;
    tick(10);
    setpoint = 22'd0;
    tick(10);

    // Play at half-period 5 across the range, then stop in a low phase at pos 2.
    t = cyc;
    setpoint = 22'd5;
    push(t + 6,  1'b0, 1'b1, 1'b0, 7'd0, "play5_first_fall");
    push(t + 11, 1'b1, 1'b1, 1'b0, 7'd1, "play5_pos1");
    push(t + 16, 1'b0, 1'b1, 1'b0, 7'd1, "play5");
    push(t + 21, 1'b1, 1'b1, 1'b0, 7'd2, "play5_pos2");
    push(t + 26, 1'b0, 1'b1, 1'b0, 7'd2, "play5");
    push(t + 31, 1'b1, 1'b0, 1'b0, 7'd3, "play5_reverse_top");
    push(t + 36, 1'b0, 1'b0, 1'b0, 7'd3, "play5");
    push(t + 41, 1'b1, 1'b0, 1'b0, 7'd2, "play5_down2");
    push(t + 46, 1'b0, 1'b0, 1'b0, 7'd2, "play5");
    push(t + 51, 1'b1, 1'b0, 1'b0, 7'd1, "play5_down1");
    push(t + 56, 1'b0, 1'b0, 1'b0, 7'd1, "play5");
    push(t + 61, 1'b1, 1'b1, 1'b0, 7'd0, "play5_reverse_bottom");
    push(t + 66, 1'b0, 1'b1, 1'b0, 7'd0, "play5");
    push(t + 71, 1'b1, 1'b1, 1'b0, 7'd1, "play5");
    push(t + 76, 1'b0, 1'b1, 1'b0, 7'd1, "play5");
    push(t + 81, 1'b1, 1'b1, 1'b0, 7'd2, "play5");
    push(t + 86, 1'b0, 1'b1, 1'b0, 7'd2, "play5");
    push(t + 88, 1'b1, 1'b0, 1'b0, 7'd3, "stop_in_low");
    tick(87);
    enable = 1'b0;
    tick(20);

    // Setpoint cut from 100 to 10 with the counter at 50.
    t = cyc;
    enable   = 1'b1;
    setpoint = 22'd100;
    push(t + 52, 1'b0, 1'b0, 1'b0, 7'd3, "retune_immediate");
    push(t + 62, 1'b1, 1'b0, 1'b0, 7'd2, "retune_half10");
    push(t + 72, 1'b0, 1'b0, 1'b0, 7'd2, "retune_half10");
    push(t + 82, 1'b1, 1'b0, 1'b0, 7'd1, "retune_half10");
    tick(51);
    setpoint = 22'd10;
    tick(34);
    enable = 1'b0;
    tick(20);

    // Asynchronous reset while step_n is low, then a full re-home.
    t = cyc;
    enable   = 1'b1;
    setpoint = 22'd5;
    push(t + 6, 1'b0, 1'b0, 1'b0, 7'd1, "pre_reset_fall");
    push(t + 7, 1'b1, 1'b0, 1'b1, 7'd3, "async_reset");
    tick(7);
    rst_n  = 1'b0;
    enable = 1'b0;
    tick(2);
    rst_n = 1'b1;
    push_homing(cyc, "rehome");
    tick(30);

    // setpoint = 1 toggles every cycle.
    t = cyc;
    enable   = 1'b1;
    setpoint = 22'd1;
    push(t + 2, 1'b0, 1'b1, 1'b0, 7'd0, "sp1");
    push(t + 3, 1'b1, 1'b1, 1'b0, 7'd1, "sp1");
    push(t + 4, 1'b0, 1'b1, 1'b0, 7'd1, "sp1");
    push(t + 5, 1'b1, 1'b1, 1'b0, 7'd2, "sp1");
    tick(5);
    enable = 1'b0;
    tick(10);

    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no event, required cycle %0d step_n=%b dir=%b busy=%b pos=%0d",
               e.nm, e.cyc, e.sn, e.d, e.b, e.p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
